// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed multi-digit seven-segment driver with
// double-buffered digit data, leading-zero blanking, per-digit decimal points
// and per-digit blinking.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   data         packed 4-bit digit values, digit i at data[4i+3:4i]
//   load         capture data/dp_mask/blink_mask into the pending buffer
//   sel          1 = hexadecimal, 0 = decimal (values 10..15 blanked)
//   lz_blank     1 = blank leading zeros (digit 0 always shown)
//   dp_mask      per-digit decimal point enable
//   blink_mask   per-digit blink enable
//   an           digit anodes, active-low, one-hot-low while scanning
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   frame_start  one-cycle pulse when the outputs first show digit 0 of a frame
module seg_scan_display #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic                      load,
    input  logic                      sel,
    input  logic                      lz_blank,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [IDX_W-1:0]            idx;
    logic [PS_W-1:0]             prescaler;
    logic [BF_W-1:0]             frame_cnt;
    logic                        blink_phase;

    logic [NUM_DIGITS-1:0][3:0]  pend_data;
    logic [NUM_DIGITS-1:0]       pend_dp;
    logic [NUM_DIGITS-1:0]       pend_blink;
    logic [NUM_DIGITS-1:0][3:0]  act_data;
    logic [NUM_DIGITS-1:0]       act_dp;
    logic [NUM_DIGITS-1:0]       act_blink;

    logic                        ps_tc;
    logic                        idx_last;
    logic                        wrap;
    logic                        fc_last;
    logic [3:0]                  cur_val;
    logic [NUM_DIGITS-1:0]       lz_vec;
    logic                        zero_above;
    logic                        blank;
    logic [6:0]                  code;

    // Scan timing terms
    always_comb begin
        ps_tc    = (prescaler == PS_W'(SCAN_DIV - 1));
        idx_last = (idx == IDX_W'(NUM_DIGITS - 1));
        wrap     = ps_tc && idx_last;
        fc_last  = (frame_cnt == BF_W'(BLINK_FRAMES - 1));
    end

    // lz_vec[i] is set when digit i and every more significant digit are zero
    always_comb begin
        lz_vec     = '0;
        zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above && (act_data[i] == 4'd0);
            lz_vec[i]  = zero_above;
        end
    end

    // Blanking decision and segment code for the digit being scanned
    always_comb begin
        cur_val = act_data[idx];
        blank   = (!sel && (cur_val >= 4'd10))
               || (lz_blank && (idx != '0) && lz_vec[idx])
               || (act_blink[idx] && blink_phase);
        code    = 7'b1111111;
        case (cur_val)
            4'h0: code = 7'b1000000;
            4'h1: code = 7'b1111001;
            4'h2: code = 7'b0100100;
            4'h3: code = 7'b0110000;
            4'h4: code = 7'b0011001;
            4'h5: code = 7'b0010010;
            4'h6: code = 7'b0000010;
            4'h7: code = 7'b1111000;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0010000;
            4'hA: code = 7'b0001000;
            4'hB: code = 7'b0000011;
            4'hC: code = 7'b1000110;
            4'hD: code = 7'b0100001;
            4'hE: code = 7'b0000110;
            4'hF: code = 7'b0001110;
            default: code = 7'b1111111;
        endcase
    end

    // Scan counters, double buffers, blink state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            prescaler   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_blink  <= '0;
            act_data    <= '0;
            act_dp      <= '0;
            act_blink   <= '0;
            an          <= '1;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (load) begin
                pend_data  <= data;
                pend_dp    <= dp_mask;
                pend_blink <= blink_mask;
            end

            prescaler <= ps_tc ? '0 : prescaler + PS_W'(1);
            if (ps_tc) begin
                idx <= idx_last ? '0 : idx + IDX_W'(1);
            end

            // Frame boundary: swap in the pending buffer (pre-load value)
            if (wrap) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                act_blink <= pend_blink;
                frame_cnt <= fc_last ? '0 : frame_cnt + BF_W'(1);
                if (fc_last) begin
                    blink_phase <= ~blink_phase;
                end
            end

            an          <= ~(NUM_DIGITS'(1) << idx);
            seg         <= blank ? 7'b1111111 : code;
            dp          <= blank | ~act_dp[idx];
            // First cycle of digit 0 is registered into the outputs next edge
            frame_start <= (idx == '0) && (prescaler == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

    localparam int unsigned ND  = 4;
    localparam int unsigned SD  = 4;
    localparam int unsigned BF  = 2;
    localparam int          FRM = 16;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;

    logic            clk = 1'b0;
    logic            rst;
    logic [4*ND-1:0] data;
    logic            load;
    logic            sel;
    logic            lz_blank;
    logic [ND-1:0]   dp_mask;
    logic [ND-1:0]   blink_mask;
    logic [ND-1:0]   an;
    logic [6:0]      seg;
    logic            dp;
    logic            frame_start;

    typedef struct {
        logic [27:0] segs;
        logic [3:0]  dpn;
        string       tag;
    } frame_t;

    frame_t sb[$];
    int     k;
    int     n_cmp;
    int     n_fail;

    seg_scan_display #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .load        (load),
        .sel         (sel),
        .lz_blank    (lz_blank),
        .dp_mask     (dp_mask),
        .blink_mask  (blink_mask),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, expv);
        end
    endtask

    // Expected frame contents, digit 0 last in the argument list
    task automatic push_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpn);
        frame_t f;
        f.segs = {s3, s2, s1, s0};
        f.dpn  = dpn;
        f.tag  = tag;
        sb.push_back(f);
    endtask

    // One clock; outputs sampled 1 time unit after the edge
    task automatic tick();
        logic        r;
        int          pos;
        int          d;
        logic [27:0] sg;
        logic [3:0]  an_e;
        r = rst;
        @(posedge clk);
        #1;
        if (r) begin
            k = 0;
            sb.delete();
            check("rst_an", 7'(an), 7'b0001111);
            check("rst_seg", seg, BL);
            check("rst_dp", 7'(dp), 7'd1);
            check("rst_frame_start", 7'(frame_start), 7'd0);
        end else begin
            k++;
            pos  = (k - 1) % FRM;
            d    = pos / int'(SD);
            an_e = ~(4'b0001 << d);
            check($sformatf("an d%0d", d), 7'(an), 7'(an_e));
            check("frame_start", 7'(frame_start), 7'(pos == 0));
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow k=%0d observed=0 expected=nonempty", k);
            end
            if (sb.size() != 0) begin
                sg = sb[0].segs;
                check($sformatf("%s seg d%0d", sb[0].tag, d), seg, sg[d*7 +: 7]);
                check($sformatf("%s dp d%0d", sb[0].tag, d), 7'(dp), 7'(sb[0].dpn[d]));
                if (pos == FRM - 1) void'(sb.pop_front());
            end
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        k          = 0;
        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        data       = '0;
        load       = 1'b0;
        sel        = 1'b1;
        lz_blank   = 1'b0;
        dp_mask    = '0;
        blink_mask = '0;

        // Reset then idle
        cycles(2);
        rst = 1'b0;
        push_frame("idle0", S0, S0, S0, S0, 4'b1111);
        push_frame("idle1", S0, S0, S0, S0, 4'b1111);
        push_frame("idle2", S0, S0, S0, S0, 4'b1111);
        cycles(37);

        // Mid-frame load of 1A3F in hex; visible from the next frame only
        data = 16'h1A3F;
        load = 1'b1;
        tick();
        load = 1'b0;
        push_frame("hex1A3F", S1, SA, S3, SF, 4'b1111);
        cycles(26);

        // Decimal mode blanks A and F
        sel = 1'b0;
        push_frame("dec1A3F", S1, BL, S3, BL, 4'b1111);
        cycles(16);

        // Double-buffer race: two loads in one frame, last one wins
        push_frame("dec1A3F_b", S1, BL, S3, BL, 4'b1111);
        cycles(2);
        data = 16'h1111;
        load = 1'b1;
        tick();
        load = 1'b0;
        cycles(3);
        data = 16'h2222;
        load = 1'b1;
        tick();
        load = 1'b0;
        push_frame("race_a", S2, S2, S2, S2, 4'b1111);
        push_frame("race_b", S2, S2, S2, S2, 4'b1111);
        cycles(29);

        // Leading-zero blanking
        lz_blank = 1'b1;
        data     = 16'h0050;
        load     = 1'b1;
        tick();
        load = 1'b0;
        push_frame("lz0050", BL, BL, S5, S0, 4'b1111);
        cycles(13);
        data = 16'h0000;
        load = 1'b1;
        tick();
        load = 1'b0;
        push_frame("lz0000", BL, BL, BL, S0, 4'b1111);
        cycles(29);

        // Blink on digit 0 and decimal point on digit 1
        lz_blank = 1'b0;
        push_frame("pre_blink", S0, S0, S0, S0, 4'b1111);
        cycles(2);
        data       = 16'h4321;
        dp_mask    = 4'b0010;
        blink_mask = 4'b0001;
        load       = 1'b1;
        tick();
        load = 1'b0;
        push_frame("blink_off_a", S4, S3, S2, BL, 4'b1101);
        push_frame("blink_on_a",  S4, S3, S2, S1, 4'b1101);
        push_frame("blink_on_b",  S4, S3, S2, S1, 4'b1101);
        push_frame("blink_off_b", S4, S3, S2, BL, 4'b1101);
        cycles(77);

        // Reset while digit 2 is lit; pending data is discarded
        push_frame("blink_off_c", S4, S3, S2, BL, 4'b1101);
        cycles(9);
        data = 16'h9999;
        load = 1'b1;
        tick();
        load = 1'b0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        push_frame("post_rst0", S0, S0, S0, S0, 4'b1111);
        push_frame("post_rst1", S0, S0, S0, S0, 4'b1111);
        cycles(32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Multi-digit, time-multiplexed seven-segment display driver for the calculator's front panel. It extends the single-digit hex/decimal decoder to a parametrised number of digits with anode scanning, double-buffered data, leading-zero blanking, per-digit decimal points and per-digit blinking. It sits between the calculator datapath, which supplies packed 4-bit digit values, and the board's shared segment bus and digit anodes.

## Interface
- NUM_DIGITS, 8, number of digits scanned (2..16); digit 0 is least significant.
- SCAN_DIV, 100000, clock cycles each digit is lit; must be at least 2.
- BLINK_FRAMES, 64, full scan frames per blink half-period; must be at least 1.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- data  in  4*NUM_DIGITS  packed digit values; digit i is data[4i+3:4i].
- load  in  1  capture data, dp_mask and blink_mask into the pending buffer.
- sel  in  1  1 = hexadecimal, 0 = decimal (values 10..15 blanked).
- lz_blank  in  1  1 = blank leading zeros.
- dp_mask  in  NUM_DIGITS  decimal point enable per digit.
- blink_mask  in  NUM_DIGITS  blink enable per digit.
- an  out  NUM_DIGITS  digit anodes, active-low, one-hot-low while scanning.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when scanning returns to digit 0.

## Operation
- Segment code table, active-low, for 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Buffering: on load = 1, the pending registers capture data, dp_mask and blink_mask. The active registers copy the pending registers only at a frame boundary, which is the cycle in which the digit index wraps from NUM_DIGITS-1 to 0. A frame therefore never mixes old and new data. If load is asserted several times within one frame, the last capture wins. If load coincides with the wrap cycle, the value captured in that cycle is not used until the next boundary.
- sel and lz_blank are not buffered; they take effect on the next digit.
- Prescaler: counts 0..SCAN_DIV-1. At its terminal count, the digit index increments modulo NUM_DIGITS.
- Blink: a frame counter counts 0..BLINK_FRAMES-1 at each frame boundary. Blink phase toggles when the counter wraps.
- Per-digit blank conditions (any one blanks the digit, driving seg = 1111111 and dp = 1):
  - sel = 0 and the value is 10 or more.
  - lz_blank = 1, and this digit and every more significant digit are 0. Digit 0 is never blanked by this rule.
  - blink_mask[i] = 1 and blink phase = 1.
- When a digit is not blanked, seg is its table code and dp = ~dp_mask[i].
- an drives bit idx low and all other bits high.

## Timing
- Reset values: idx = 0, prescaler = 0, frame counter = 0, blink phase = 0, pending and active buffers all zero, an all ones, seg = 1111111, dp = 1, frame_start = 0.
- an, seg and dp are registered and update one cycle after idx changes. The first lit digit (digit 0) appears in the second cycle after rst deasserts.
- Each digit is lit for exactly SCAN_DIV cycles. A frame lasts NUM_DIGITS*SCAN_DIV cycles.
- frame_start is high for one cycle, in the same cycle that the outputs first show digit 0 of a new frame. The active buffer is already updated in that cycle.
- Data that is loaded appears on the outputs no later than the start of the frame after the next boundary, and no earlier than the next boundary.
- rst asserted mid-frame returns all state and outputs to their reset values on the next clock edge. Pending data is discarded.

## Test plan
Simulation parameters: NUM_DIGITS = 4, SCAN_DIV = 4, BLINK_FRAMES = 2.
- Reset then idle: after rst, an cycles 1110, 1101, 1011, 0111, with 4 cycles each. seg = 1000000 on every digit, and frame_start pulses every 16 cycles.
- Load data = 16'h1A3F with sel = 1 mid-frame: the current frame still shows 0000. Digits 0..3 of the next frame show 0001110, 0110000, 0001000, 1111001. Repeating with sel = 0 makes digits 0 and 2 show 1111111.
- Double-buffer race: load 16'h1111, then 16'h2222 in the same frame. Only 2222 (0100100 on each digit) is ever displayed.
- Leading zeros: load 16'h0050 with lz_blank = 1. Digits 3 and 2 show 1111111, digit 1 shows 0010010 and digit 0 shows 1000000. Loading 16'h0000 leaves only digit 0 lit.
- Blink and dp: blink_mask = 0001 and dp_mask = 0010. Digit 0 is blank in alternating pairs of frames. dp is 0 only while an = 1101.
- Reset mid-frame: assert rst while an = 1011. On the next edge an = 1111 and seg = 1111111, and the display resumes from digit 0 with zero data.
